// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encodings, flag bit positions and default datapath width
package alu_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; prio breaks ties, advance gates the grant
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       prio,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       idx
);
  always_comb begin
    idx = (valid == 2'b11) ? prio : valid[1];
    grant = (advance && valid != 2'b00) ? (2'b01 << idx) : 2'b00;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with a one-entry response buffer
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_src_a,
  input  logic [WIDTH-1:0] req0_src_b,
  input  logic [1:0]       req0_ctrl,
  input  logic             req0_set_flags,
  input  logic [WIDTH-1:0] req1_src_a,
  input  logic [WIDTH-1:0] req1_src_b,
  input  logic [1:0]       req1_ctrl,
  input  logic             req1_set_flags,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [1:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       flags
);
  logic prio, idx, can_accept, accept, sel_set_flags;
  logic [1:0] grant;
  assign can_accept = !rsp_valid || rsp_ready;
  assign accept = grant != 2'b00;
  assign req_ready = grant;
  rr_arbiter2 u_arb (
    .valid(req_valid),
    .prio(prio),
    .advance(can_accept),
    .grant(grant),
    .idx(idx)
  );
  always_comb begin
    alu_src_a = !accept ? '0 : idx ? req1_src_a : req0_src_a;
    alu_src_b = !accept ? '0 : idx ? req1_src_b : req0_src_b;
    alu_control = !accept ? ALU_ADD : idx ? req1_ctrl : req0_ctrl;
    sel_set_flags = idx ? req1_set_flags : req0_set_flags;
  end
  // a drain with a simultaneous accept reloads the buffer, keeping rsp_valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_flags <= 4'b0000;
      flags <= FLAGS_RESET;
      prio <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id <= idx;
      rsp_result <= alu_result;
      rsp_flags <= alu_flags;
      prio <= ~idx;
      if (sel_set_flags) flags <= alu_flags;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] pend = 2'b00, req_ready, alu_control;
  logic [31:0] pa[2], pb[2];
  logic [1:0] pc[2];
  logic ps[2];
  logic [31:0] alu_src_a, alu_src_b, alu_result, rsp_result;
  logic [3:0] alu_flags, rsp_flags, flags;
  logic rsp_valid, rsp_ready = 1'b0, rsp_id;
  int n_vec = 0, n_bad = 0;
  bit e_valid = 0, e_id = 0, turn = 0;
  logic [31:0] e_res = '0;
  logic [3:0] e_rf = '0, e_flags = '0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .FLAGS_RESET(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(pend), .req_ready(req_ready),
    .req0_src_a(pa[0]), .req0_src_b(pb[0]), .req0_ctrl(pc[0]), .req0_set_flags(ps[0]),
    .req1_src_a(pa[1]), .req1_src_b(pb[1]), .req1_ctrl(pc[1]), .req1_set_flags(ps[1]),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags(flags)
  );

  // reference ALU: returns {N,Z,C,V, result}; C on subtract means no borrow
  function automatic logic [35:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    if (op == 2'd0) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[31:0];
      c = s[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (op == 2'd1) begin
      s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      r = s[31:0];
      c = s[32];
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end else begin
      r = (op == 2'd2) ? (a & b) : (a | b);
    end
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu(alu_src_a, alu_src_b, alu_control);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic sf);
    pa[i] = a;
    pb[i] = b;
    pc[i] = op;
    ps[i] = sf;
    pend[i] = 1'b1;
  endtask

  // called in the low clock phase with inputs settled; checks, then advances one cycle
  task automatic tick();
    int g;
    logic [35:0] o;
    g = (pend == 2'b00 || !(!e_valid || rsp_ready)) ? -1 : (pend == 2'b11) ? int'(turn) : int'(pend[1]);
    #1;
    chk("req_ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
    chk("rsp_valid", rsp_valid, e_valid);
    chk("flags", flags, e_flags);
    if (e_valid) begin
      chk("rsp_id", rsp_id, e_id);
      chk("rsp_result", rsp_result, e_res);
      chk("rsp_flags", rsp_flags, e_rf);
    end
    if (g >= 0) begin
      chk("alu_src_a", alu_src_a, pa[g]);
      chk("alu_src_b", alu_src_b, pb[g]);
      chk("alu_control", alu_control, pc[g]);
    end
    @(posedge clk);
    @(negedge clk);
    if (g >= 0) begin
      o = alu(pa[g], pb[g], pc[g]);
      e_res = o[31:0];
      e_rf = o[35:32];
      e_id = g[0];
      e_valid = 1;
      if (ps[g]) e_flags = o[35:32];
      turn = !g[0];
      pend[g] = 1'b0;
    end else if (rsp_ready) begin
      e_valid = 0;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    int k;
    k = $urandom_range(0, 5);
    return (k == 0) ? 32'd0 : (k == 1) ? 32'hFFFF_FFFF : (k == 2) ? 32'h8000_0000 :
           (k == 3) ? 32'h7FFF_FFFF : $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      pa[i] = '0; pb[i] = '0; pc[i] = 2'b00; ps[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_id", rsp_id, 0);
    chk("reset rsp_result", rsp_result, 0);
    chk("reset rsp_flags", rsp_flags, 0);
    chk("reset flags", flags, 4'b0000);
    chk("reset req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b1;
    issue(0, 32'd5, 32'd3, 2'd0, 1'b1);
    tick();
    chk("add5+3 valid", rsp_valid, 1);
    chk("add5+3 id", rsp_id, 0);
    chk("add5+3 result", rsp_result, 32'd8);
    chk("add5+3 flags", flags, 4'b0000);
    issue(0, 32'h7FFF_FFFF, 32'd1, 2'd0, 1'b1);
    tick();
    chk("ovf result", rsp_result, 32'h8000_0000);
    chk("ovf flags", flags, 4'b1001);
    issue(1, 32'd7, 32'd7, 2'd1, 1'b0);
    tick();
    chk("sub7-7 id", rsp_id, 1);
    chk("sub7-7 result", rsp_result, 32'd0);
    chk("sub7-7 rsp_flags", rsp_flags, 4'b0110);
    chk("sub7-7 arch flags", flags, 4'b1001);
    for (int k = 0; k < 8; k++) begin
      if (!pend[0]) issue(0, 32'(k), 32'd100, 2'd0, 1'b0);
      if (!pend[1]) issue(1, 32'(k), 32'd200, 2'd3, 1'b0);
      tick();
      chk("alternate id", rsp_id, k % 2);
    end
    pend = 2'b00;
    tick();
    issue(0, 32'hF0, 32'h3C, 2'd2, 1'b0);
    tick();
    rsp_ready = 1'b0;
    issue(0, 32'd40, 32'd2, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall req_ready", req_ready, 0);
      chk("stall result", rsp_result, 32'h30);
    end
    rsp_ready = 1'b1;
    tick();
    chk("drain+accept valid", rsp_valid, 1);
    chk("drain+accept result", rsp_result, 32'd42);
    for (int k = 0; k < 4; k++) begin
      issue(0, 32'(k), 32'd10, 2'd0, 1'b0);
      tick();
      chk("stream valid", rsp_valid, 1);
      chk("stream result", rsp_result, 32'(k + 10));
    end
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset rsp_valid", rsp_valid, 0);
    chk("async reset flags", flags, 4'b0000);
    e_valid = 0; e_flags = 4'b0000; turn = 0; pend = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 3) != 0)
          issue(i, rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
